// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS control path.
// Holds opcodes, ALU/mux select codes and the controller state type.
package mips_pkg;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_ADDI = 6'h08;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
    S_RWB, S_ADDI_EX, S_ADDI_WB, S_BRANCH, S_JUMP, S_FAULT
  } ctrl_state_t;

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Controller <-> datapath/memory signal bundle.
// master = control unit, slave = datapath and memory side.
interface mips_multicycle_ctrl_if #(parameter int CNT_W = 32);
  logic [5:0]       OPCODE;
  logic             ZERO;
  logic             MEM_READY;
  logic             PC_EN;
  logic             IORD;
  logic             MEM_READ;
  logic             MEM_WRITE;
  logic             IR_WRITE;
  logic             REG_DST;
  logic             MEM_TO_REG;
  logic             REG_WRITE;
  logic             ALU_SRC_A;
  logic [1:0]       ALU_SRC_B;
  logic [1:0]       ALU_OP;
  logic [1:0]       PC_SOURCE;
  logic             ILLEGAL_OP;
  logic             FAULT;
  logic [CNT_W-1:0] INSTR_COUNT;

  modport master (
    input  OPCODE, ZERO, MEM_READY,
    output PC_EN, IORD, MEM_READ, MEM_WRITE, IR_WRITE, REG_DST, MEM_TO_REG,
           REG_WRITE, ALU_SRC_A, ALU_SRC_B, ALU_OP, PC_SOURCE, ILLEGAL_OP,
           FAULT, INSTR_COUNT
  );

  modport slave (
    output OPCODE, ZERO, MEM_READY,
    input  PC_EN, IORD, MEM_READ, MEM_WRITE, IR_WRITE, REG_DST, MEM_TO_REG,
           REG_WRITE, ALU_SRC_A, ALU_SRC_B, ALU_OP, PC_SOURCE, ILLEGAL_OP,
           FAULT, INSTR_COUNT
  );
endinterface

// File: rtl/mips_mem_wait_timer.sv
// Counts consecutive memory wait cycles; expired flags the last allowed one.
module mips_mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic clr,
  input  logic cnt_en,
  output logic expired
);
  localparam int TW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

  logic [TW-1:0] cnt;

  assign expired = (cnt == TW'(MEM_TIMEOUT - 1));

  // Holds at the limit; the controller leaves the wait state on expiry anyway.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)                cnt <= '0;
    else if (clr)                cnt <= '0;
    else if (cnt_en && !expired) cnt <= cnt + TW'(1);
  end
endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS main control FSM with retired-instruction counter
// and sticky memory-timeout fault.
module mips_multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  mips_multicycle_ctrl_if.master bus
);
  ctrl_state_t      state, state_nxt;
  logic             in_wait, tmr_exp, retire;
  logic [CNT_W-1:0] instr_cnt;

  assign in_wait = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);

  // Leaving a wait state (or sitting elsewhere) rearms the timer for the next entry.
  mips_mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_tmr (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .clr     (!in_wait || bus.MEM_READY),
    .cnt_en  (in_wait && !bus.MEM_READY),
    .expired (tmr_exp)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= S_FETCH;
    else          state <= state_nxt;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)    instr_cnt <= '0;
    else if (retire) instr_cnt <= instr_cnt + CNT_W'(1);
  end

  assign bus.INSTR_COUNT = instr_cnt;

  always_comb begin
    state_nxt      = state;
    retire         = 1'b0;
    bus.PC_EN      = 1'b0;
    bus.IORD       = 1'b0;
    bus.MEM_READ   = 1'b0;
    bus.MEM_WRITE  = 1'b0;
    bus.IR_WRITE   = 1'b0;
    bus.REG_DST    = 1'b0;
    bus.MEM_TO_REG = 1'b0;
    bus.REG_WRITE  = 1'b0;
    bus.ALU_SRC_A  = 1'b0;
    bus.ALU_SRC_B  = SRCB_REG;
    bus.ALU_OP     = ALUOP_ADD;
    bus.PC_SOURCE  = PCSRC_ALU;
    bus.ILLEGAL_OP = 1'b0;
    bus.FAULT      = 1'b0;
    unique case (state)
      S_FETCH: begin
        bus.MEM_READ  = 1'b1;
        bus.ALU_SRC_B = SRCB_FOUR;
        bus.PC_EN     = bus.MEM_READY;
        bus.IR_WRITE  = bus.MEM_READY;
        if (bus.MEM_READY) state_nxt = S_DECODE;
        else if (tmr_exp)  state_nxt = S_FAULT;
      end
      S_DECODE: begin
        bus.ALU_SRC_B = SRCB_IMM_SH2;
        unique case (bus.OPCODE)
          OP_R:          state_nxt = S_EXEC;
          OP_LW, OP_SW:  state_nxt = S_MEMADR;
          OP_BEQ:        state_nxt = S_BRANCH;
          OP_J:          state_nxt = S_JUMP;
          OP_ADDI:       state_nxt = S_ADDI_EX;
          default: begin
            bus.ILLEGAL_OP = 1'b1;
            state_nxt      = S_FETCH;
          end
        endcase
      end
      S_MEMADR, S_ADDI_EX: begin
        bus.ALU_SRC_A = 1'b1;
        bus.ALU_SRC_B = SRCB_IMM;
        if (state == S_ADDI_EX)       state_nxt = S_ADDI_WB;
        else if (bus.OPCODE == OP_LW) state_nxt = S_MEMRD;
        else                          state_nxt = S_MEMWR;
      end
      S_MEMRD: begin
        bus.MEM_READ = 1'b1;
        bus.IORD     = 1'b1;
        if (bus.MEM_READY) state_nxt = S_MEMWB;
        else if (tmr_exp)  state_nxt = S_FAULT;
      end
      S_MEMWR: begin
        bus.MEM_WRITE = 1'b1;
        bus.IORD      = 1'b1;
        if (bus.MEM_READY) begin
          retire    = 1'b1;
          state_nxt = S_FETCH;
        end else if (tmr_exp) begin
          state_nxt = S_FAULT;
        end
      end
      S_MEMWB: begin
        bus.REG_WRITE  = 1'b1;
        bus.MEM_TO_REG = 1'b1;
        retire         = 1'b1;
        state_nxt      = S_FETCH;
      end
      S_EXEC: begin
        bus.ALU_SRC_A = 1'b1;
        bus.ALU_OP    = ALUOP_FUNCT;
        state_nxt     = S_RWB;
      end
      S_RWB, S_ADDI_WB: begin
        bus.REG_WRITE = 1'b1;
        bus.REG_DST   = (state == S_RWB);
        retire        = 1'b1;
        state_nxt     = S_FETCH;
      end
      S_BRANCH: begin
        bus.ALU_SRC_A = 1'b1;
        bus.ALU_OP    = ALUOP_SUB;
        bus.PC_SOURCE = PCSRC_ALUOUT;
        bus.PC_EN     = bus.ZERO;
        retire        = 1'b1;
        state_nxt     = S_FETCH;
      end
      S_JUMP: begin
        bus.PC_SOURCE = PCSRC_JUMP;
        bus.PC_EN     = 1'b1;
        retire        = 1'b1;
        state_nxt     = S_FETCH;
      end
      S_FAULT: bus.FAULT = 1'b1;
      default: state_nxt = S_FETCH;
    endcase
  end
endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Multi-cycle main control unit for the MIPS datapath. Sequences each instruction through fetch, decode, execute, memory and writeback states, driving the PC, instruction register, register file, ALU control and memory enables. It sits between the instruction register (opcode source) and the datapath muxes, consumes `Zero` from the ALU and a ready handshake from memory. It also keeps a retired-instruction count and a sticky memory-timeout fault.

## Interface
- `MEM_TIMEOUT`, 16: max cycles a memory state waits for `MEM_READY` before faulting (≥2).
- `CNT_W`, 32: width of `INSTR_COUNT`.
- `CLK` in 1: single clock, all state updates on posedge.
- `RESET_N` in 1: asynchronous, active-low reset.
- `OPCODE` in 6: instruction[31:26] from the instruction register.
- `ZERO` in 1: ALU zero flag.
- `MEM_READY` in 1: memory completes the current access this cycle.
- `PC_EN` out 1: PC load enable.
- `IORD` out 1: memory address select, 0=PC, 1=ALUOut.
- `MEM_READ`, `MEM_WRITE` out 1: memory strobes.
- `IR_WRITE` out 1: instruction register load.
- `REG_DST` out 1: write register select, 0=rt, 1=rd.
- `MEM_TO_REG` out 1: writeback select, 0=ALUOut, 1=MDR.
- `REG_WRITE` out 1: register file write enable.
- `ALU_SRC_A` out 1: 0=PC, 1=A.
- `ALU_SRC_B` out 2: 00=B, 01=4, 10=signext imm, 11=signext imm<<2.
- `ALU_OP` out 2: 00=add, 01=sub, 10=use funct.
- `PC_SOURCE` out 2: 00=ALU result, 01=ALUOut, 10=jump target.
- `ILLEGAL_OP` out 1: one-cycle pulse in DECODE on an unknown opcode.
- `FAULT` out 1: sticky memory-timeout flag.
- `INSTR_COUNT` out `CNT_W`: retired instructions.

## Operation
- Opcodes: R=0x00, LW=0x23, SW=0x2B, BEQ=0x04, J=0x02, ADDI=0x08.
- States and transitions:
  - FETCH→DECODE on `MEM_READY`.
  - DECODE → MEMADR (LW/SW), EXEC (R), BRANCH (BEQ), JUMP (J), ADDI_EX (ADDI). Any other opcode → FETCH.
  - MEMADR → MEMRD (LW) or MEMWR (SW).
  - MEMRD→MEMWB on ready; MEMWB→FETCH.
  - MEMWR→FETCH on ready.
  - EXEC→RWB→FETCH.
  - ADDI_EX→ADDI_WB→FETCH.
  - BRANCH→FETCH; JUMP→FETCH.
  - FAULT is absorbing until reset.
- Outputs are Moore-decoded from state. The exceptions are `PC_EN`/`IR_WRITE` in FETCH and `PC_EN` in BRANCH. All unlisted outputs are 0.
  - FETCH: `MEM_READ`=1, `IORD`=0, `ALU_SRC_A`=0, `ALU_SRC_B`=01, `ALU_OP`=00, `PC_SOURCE`=00. `PC_EN` and `IR_WRITE` equal `MEM_READY`.
  - DECODE: `ALU_SRC_A`=0, `ALU_SRC_B`=11, `ALU_OP`=00. `ILLEGAL_OP` is 1 if the opcode is unknown.
  - MEMADR and ADDI_EX: `ALU_SRC_A`=1, `ALU_SRC_B`=10, `ALU_OP`=00.
  - MEMRD: `MEM_READ`=1, `IORD`=1.
  - MEMWR: `MEM_WRITE`=1, `IORD`=1.
  - MEMWB: `REG_WRITE`=1, `MEM_TO_REG`=1, `REG_DST`=0.
  - EXEC: `ALU_SRC_A`=1, `ALU_SRC_B`=00, `ALU_OP`=10.
  - RWB: `REG_WRITE`=1, `REG_DST`=1, `MEM_TO_REG`=0.
  - ADDI_WB: `REG_WRITE`=1, `REG_DST`=0, `MEM_TO_REG`=0.
  - BRANCH: `ALU_SRC_A`=1, `ALU_SRC_B`=00, `ALU_OP`=01, `PC_SOURCE`=01, `PC_EN`=`ZERO`.
  - JUMP: `PC_SOURCE`=10, `PC_EN`=1.
  - FAULT: all strobes 0, `FAULT`=1.
- Wait timer:
  - Cleared on entry to FETCH, MEMRD and MEMWR; increments each cycle in those states while `MEM_READY`=0.
  - If `MEM_READY`=0 with the timer at `MEM_TIMEOUT`-1, next state is FAULT.
  - `MEM_READY` on that same cycle wins: normal transition, no fault.
- `INSTR_COUNT` increments by 1, wrapping modulo 2^`CNT_W`, on:
  - the final cycle of each instruction: MEMWB, RWB, ADDI_WB, BRANCH (taken or not), JUMP;
  - MEMWR when `MEM_READY`=1.
  - Illegal opcodes do not count.

## Timing
- Reset (asynchronous, any state, mid-access included):
  - state=FETCH, timer=0, `INSTR_COUNT`=0, `FAULT`=0.
  - Outputs take FETCH decode immediately: `MEM_READ`=1, `ALU_SRC_B`=01, all else 0, `PC_EN`/`IR_WRITE` follow `MEM_READY`.
- Cycles with zero wait states: R 4, ADDI 4, LW 5, SW 4, BEQ 3, J 3, illegal 2. Each memory wait cycle adds 1.
- `MEM_READ`/`MEM_WRITE` are held steady until the cycle `MEM_READY`=1. The access completes that cycle.
- `MEM_READY` outside FETCH/MEMRD/MEMWR is ignored.
- `ZERO` is sampled only in BRANCH.

## Structure
- Shared package `mips_pkg` holds:
  - opcode constants;
  - `ALU_OP` encodings;
  - `ALU_SRC_B`/`PC_SOURCE` encodings;
  - state enum type `ctrl_state_t`.
- Sub-module `mips_mem_wait_timer` (clear, count-enable, parameter `MEM_TIMEOUT`, `expired` output). Everything else lives in one FSM module.

## Test plan
- Reset then `MEM_READY` held 1, `OPCODE`=0x00:
  - state sequence FETCH,DECODE,EXEC,RWB,FETCH;
  - `REG_WRITE`=1 only in RWB;
  - `INSTR_COUNT`=1 after 4 cycles.
- `OPCODE`=0x23 with 2 wait cycles in MEMRD:
  - `MEM_READ`/`IORD`=1 for 3 cycles;
  - `MEM_TO_REG`=1 in MEMWB;
  - total 7 cycles.
- `OPCODE`=0x04 with `ZERO`=1 then 0: `PC_EN`=1 then 0 in BRANCH, `PC_SOURCE`=01; count increments both times.
- `OPCODE`=0x3F: `ILLEGAL_OP` pulses 1 cycle in DECODE, return to FETCH, count unchanged.
- `MEM_TIMEOUT`=4, `MEM_READY`=0 in FETCH:
  - FAULT entered after 4 cycles, `FAULT` stays 1;
  - `RESET_N` low→FETCH, `FAULT`=0.
  - Repeat with ready on the 4th cycle: no fault.
- `RESET_N` asserted mid-MEMWR: `MEM_WRITE` drops asynchronously, `INSTR_COUNT`=0.
